// File: rtl/encap_mac_inserter.sv
// encap_mac_inserter: prepends a 14-byte outer Ethernet header (dst MAC,
// src MAC, EtherType) to each AXI-Stream packet on a 64-bit bus. Header
// fields come from a per-ID config table addressed by tdest; IDs with
// encapsulation disabled are forwarded unchanged.
//
// Handshake: a beat moves on a rising edge when valid && ready are both high.
// The output register loads whenever it is empty or being drained
// (ld = !out_tvalid || out_tready). While out_tvalid && !out_tready, every
// output field is held. axis_in_tready never depends on axis_in_tvalid.
module encap_mac_inserter #(
    parameter  int AXIS_ID_WIDTH  = 4,
    parameter  int AXIS_BUS_WIDTH = 64,
    localparam int EFF_ID_WIDTH   = (AXIS_ID_WIDTH > 1) ? AXIS_ID_WIDTH : 1
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [63:0]              axis_in_tdata,
    input  logic [AXIS_ID_WIDTH:0]   axis_in_tdest,
    input  logic [7:0]               axis_in_tkeep,
    input  logic                     axis_in_tlast,
    input  logic                     axis_in_tvalid,
    output logic                     axis_in_tready,
    output logic [63:0]              axis_out_tdata,
    output logic [AXIS_ID_WIDTH:0]   axis_out_tdest,
    output logic [7:0]               axis_out_tkeep,
    output logic                     axis_out_tlast,
    output logic                     axis_out_tvalid,
    input  logic                     axis_out_tready,
    output logic [EFF_ID_WIDTH-1:0]  encap_config_sel,
    input  logic [112:0]             encap_config_regs
);

    if (AXIS_BUS_WIDTH != 64) begin : g_bus_width_check
        $error("encap_mac_inserter: AXIS_BUS_WIDTH must be 64");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR1,
        ST_SHIFT,
        ST_TAIL,
        ST_PASS
    } state_t;

    state_t                   state_q, state_d;
    logic [63:0]              dout_q, dout_d;
    logic [7:0]               dkeep_q, dkeep_d;
    logic                     dlast_q, dlast_d;
    logic                     dvalid_q;
    logic [AXIS_ID_WIDTH:0]   ddest_q, ddest_d;
    logic [47:0]              r_q, r_d;
    logic [3:0]               n_q, n_d;
    // Only the header bytes still needed after the first header beat are kept.
    logic [31:0]              src_q;
    logic [15:0]              et_q;
    logic [EFF_ID_WIDTH-1:0]  sel_q;
    logic [AXIS_ID_WIDTH:0]   dest_q;

    logic        ld, emit, in_ready, cfg_load;
    logic [63:0] d_data;
    logic [3:0]  last_n;
    logic        cfg_en;
    logic [47:0] cfg_dst, cfg_src;
    logic [15:0] cfg_et;
    logic [63:0] hdr_beat0;
    logic [47:0] hdr_tail;

    assign ld      = !dvalid_q || axis_out_tready;
    assign last_n  = 4'($countones(axis_in_tkeep));
    assign cfg_en  = encap_config_regs[112];
    assign cfg_dst = encap_config_regs[111:64];
    assign cfg_src = encap_config_regs[63:16];
    assign cfg_et  = encap_config_regs[15:0];

    // Header bytes 0-7 come straight from the live table entry (IDLE only);
    // bytes 8-13 come from the copy latched at packet start.
    assign hdr_beat0 = {cfg_src[39:32], cfg_src[47:40],
                        cfg_dst[7:0], cfg_dst[15:8], cfg_dst[23:16],
                        cfg_dst[31:24], cfg_dst[39:32], cfg_dst[47:40]};
    assign hdr_tail  = {et_q[7:0], et_q[15:8],
                        src_q[7:0], src_q[15:8], src_q[23:16], src_q[31:24]};

    assign encap_config_sel = (state_q == ST_IDLE) ? axis_in_tdest[EFF_ID_WIDTH-1:0] : sel_q;
    assign axis_in_tready   = in_ready && !areset;

    assign axis_out_tdata  = dout_q;
    assign axis_out_tkeep  = dkeep_q;
    assign axis_out_tlast  = dlast_q;
    assign axis_out_tvalid = dvalid_q;
    assign axis_out_tdest  = ddest_q;

    function automatic logic [63:0] keep_mask(input logic [7:0] k);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{k[i]}};
        return m;
    endfunction

    // Next-state, output-beat and residual selection.
    always_comb begin
        state_d  = state_q;
        emit     = 1'b0;
        in_ready = 1'b0;
        cfg_load = 1'b0;
        d_data   = '0;
        dkeep_d  = '0;
        dlast_d  = 1'b0;
        ddest_d  = axis_in_tdest;
        r_d      = r_q;
        n_d      = n_q;
        case (state_q)
            ST_IDLE: begin
                in_ready = ld && !cfg_en;
                if (axis_in_tvalid && ld) begin
                    cfg_load = 1'b1;
                    emit     = 1'b1;
                    if (cfg_en) begin
                        d_data  = hdr_beat0;
                        dkeep_d = 8'hFF;
                        state_d = ST_HDR1;
                    end else begin
                        d_data  = axis_in_tdata;
                        dkeep_d = axis_in_tkeep;
                        dlast_d = axis_in_tlast;
                        state_d = axis_in_tlast ? ST_IDLE : ST_PASS;
                    end
                end
            end
            ST_HDR1, ST_SHIFT: begin
                in_ready = ld;
                if (axis_in_tvalid && ld) begin
                    emit   = 1'b1;
                    d_data = {axis_in_tdata[15:0], ((state_q == ST_HDR1) ? hdr_tail : r_q)};
                    r_d    = axis_in_tdata[63:16];
                    if (!axis_in_tlast) begin
                        dkeep_d = 8'hFF;
                        state_d = ST_SHIFT;
                    end else if (last_n <= 4'd2) begin
                        dkeep_d = 8'hFF >> (4'd2 - last_n);
                        dlast_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        dkeep_d = 8'hFF;
                        n_d     = last_n;
                        state_d = ST_TAIL;
                    end
                end
            end
            ST_TAIL: begin
                if (ld) begin
                    emit    = 1'b1;
                    d_data  = {16'h0000, r_q};
                    dkeep_d = 8'hFF >> (4'd10 - n_q);
                    dlast_d = 1'b1;
                    ddest_d = dest_q;
                    state_d = ST_IDLE;
                end
            end
            ST_PASS: begin
                in_ready = ld;
                if (axis_in_tvalid && ld) begin
                    emit    = 1'b1;
                    d_data  = axis_in_tdata;
                    dkeep_d = axis_in_tkeep;
                    dlast_d = axis_in_tlast;
                    state_d = axis_in_tlast ? ST_IDLE : ST_PASS;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Lanes not covered by tkeep always read as zero.
        dout_d = d_data & keep_mask(dkeep_d);
    end

    // State, residual, latched config and the registered output beat.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q  <= ST_IDLE;
            r_q      <= '0;
            n_q      <= '0;
            src_q    <= '0;
            et_q     <= '0;
            sel_q    <= '0;
            dest_q   <= '0;
            dout_q   <= '0;
            dkeep_q  <= '0;
            dlast_q  <= 1'b0;
            dvalid_q <= 1'b0;
            ddest_q  <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            n_q     <= n_d;
            if (cfg_load) begin
                src_q  <= cfg_src[31:0];
                et_q   <= cfg_et;
                sel_q  <= axis_in_tdest[EFF_ID_WIDTH-1:0];
                dest_q <= axis_in_tdest;
            end
            if (ld) begin
                dvalid_q <= emit;
                if (emit) begin
                    dout_q  <= dout_d;
                    dkeep_q <= dkeep_d;
                    dlast_q <= dlast_d;
                    ddest_q <= ddest_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_encap_mac_inserter.sv
// Bench for encap_mac_inserter: table of directed packets, hand-written
// back-to-back and mid-packet reset sequences, and a randomized phase with
// random output backpressure checked against a byte-stream reference model.
module tb_encap_mac_inserter;

    localparam int IDW = 4;
    localparam int DW  = IDW + 1;
    localparam int BW  = DW + 1 + 8 + 64;
    localparam logic [63:0] HDR1_BEAT0 = 64'h0002_0100_0000_0002;

    logic            aclk;
    logic            areset;
    logic [63:0]     in_tdata;
    logic [DW-1:0]   in_tdest;
    logic [7:0]      in_tkeep;
    logic            in_tlast, in_tvalid, in_tready;
    logic [63:0]     out_tdata;
    logic [DW-1:0]   out_tdest;
    logic [7:0]      out_tkeep;
    logic            out_tlast, out_tvalid, out_tready;
    logic [IDW-1:0]  cfg_sel;
    logic [112:0]    cfg_regs;
    logic [112:0]    cfg_tbl [16];

    assign cfg_regs = cfg_tbl[cfg_sel];

    encap_mac_inserter #(.AXIS_ID_WIDTH(IDW), .AXIS_BUS_WIDTH(64)) dut (
        .aclk              (aclk),
        .areset            (areset),
        .axis_in_tdata     (in_tdata),
        .axis_in_tdest     (in_tdest),
        .axis_in_tkeep     (in_tkeep),
        .axis_in_tlast     (in_tlast),
        .axis_in_tvalid    (in_tvalid),
        .axis_in_tready    (in_tready),
        .axis_out_tdata    (out_tdata),
        .axis_out_tdest    (out_tdest),
        .axis_out_tkeep    (out_tkeep),
        .axis_out_tlast    (out_tlast),
        .axis_out_tvalid   (out_tvalid),
        .axis_out_tready   (out_tready),
        .encap_config_sel  (cfg_sel),
        .encap_config_regs (cfg_regs)
    );

    // ---------------- clock / reset / cycle counter ----------------
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    bit rand_ready = 1'b0;
    always @(posedge aclk) begin
        #1;
        out_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // ---------------- scoreboard state ----------------
    logic [BW-1:0] exp_q[$];
    int            tests_run = 0;
    int            tests_failed = 0;
    bit            sb_off = 1'b0;
    logic [7:0]    pay [64];

    int            start_cyc_q[$];
    int            first_cyc_q[$];
    int            last_cyc_q[$];
    int            beats_q[$];
    logic [63:0]   first_data_q[$];
    logic [7:0]    last_keep_q[$];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] req);
        tests_run++;
        if (got !== req) begin
            tests_failed++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic clear_stats();
        start_cyc_q.delete();
        first_cyc_q.delete();
        last_cyc_q.delete();
        beats_q.delete();
        first_data_q.delete();
        last_keep_q.delete();
    endtask

    task automatic fill_pay(input int nbytes, input int base, input int step);
        for (int i = 0; i < nbytes; i++) pay[i] = 8'(base + i * step);
    endtask

    // Reference model: the output is the byte stream (header ++ payload, or
    // just payload when disabled) cut into 8-byte beats.
    task automatic push_expected(input logic [DW-1:0] dest, input int nbytes);
        logic [7:0]    bytes[$];
        logic [112:0]  c;
        logic [63:0]   d;
        logic [7:0]    k;
        logic          l;
        c = cfg_tbl[dest[IDW-1:0]];
        if (c[112]) begin
            for (int i = 5; i >= 0; i--) bytes.push_back(c[64 + 8*i +: 8]);
            for (int i = 5; i >= 0; i--) bytes.push_back(c[16 + 8*i +: 8]);
            bytes.push_back(c[15:8]);
            bytes.push_back(c[7:0]);
        end
        for (int i = 0; i < nbytes; i++) bytes.push_back(pay[i]);
        for (int b = 0; b * 8 < bytes.size(); b++) begin
            d = '0;
            k = '0;
            for (int i = 0; i < 8; i++) begin
                if (b * 8 + i < bytes.size()) begin
                    d[8*i +: 8] = bytes[b * 8 + i];
                    k[i] = 1'b1;
                end
            end
            l = ((b + 1) * 8 >= bytes.size());
            exp_q.push_back({dest, l, k, d});
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive_beat(input int b, input int nbytes, input logic [DW-1:0] dest);
        int rem;
        rem = nbytes - 8 * b;
        in_tdata = '0;
        in_tkeep = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < rem) begin
                in_tdata[8*i +: 8] = pay[8 * b + i];
                in_tkeep[i] = 1'b1;
            end
        end
        in_tlast  = (rem <= 8);
        in_tdest  = dest;
        in_tvalid = 1'b1;
    endtask

    task automatic send_pkt(input logic [DW-1:0] dest, input int nbytes, input bit gaps);
        int beats;
        int t;
        beats = (nbytes + 7) / 8;
        for (int b = 0; b < beats; b++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_tvalid = 1'b0;
                @(posedge aclk);
                #1;
            end
            drive_beat(b, nbytes, dest);
            if (b == 0) start_cyc_q.push_back(cyc);
            t = 0;
            do begin
                @(negedge aclk);
                t++;
            end while (!in_tready && t < 1000);
            if (!in_tready) begin
                tests_run++;
                tests_failed++;
                $display("FAIL drv_timeout: beat %0d never accepted, required acceptance", b);
                in_tvalid = 1'b0;
                return;
            end
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(posedge aclk);
            t++;
        end
        check("drain_outstanding", exp_q.size(), 0);
        repeat (2) @(posedge aclk);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    int            cur_beats = 0;
    int            cur_first = 0;
    logic [63:0]   cur_first_data;
    bit            prev_hold = 1'b0;
    logic [BW-1:0] prev_beat, cur_beat, exp_beat;

    always @(negedge aclk) begin
        if (areset) begin
            cur_beats = 0;
            prev_hold = 1'b0;
        end else begin
            cur_beat = {out_tdest, out_tlast, out_tkeep, out_tdata};
            if (prev_hold) begin
                tests_run++;
                if (!out_tvalid || cur_beat !== prev_beat) begin
                    tests_failed++;
                    $display("FAIL stall_hold: got valid=%0b beat=%h, required valid=1 beat=%h",
                             out_tvalid, cur_beat, prev_beat);
                end
            end
            prev_hold = out_tvalid && !out_tready;
            prev_beat = cur_beat;
            if (out_tvalid && out_tready) begin
                if (cur_beats == 0) begin
                    cur_first      = cyc;
                    cur_first_data = out_tdata;
                end
                cur_beats++;
                if (!sb_off) begin
                    tests_run++;
                    if (exp_q.size() == 0) begin
                        tests_failed++;
                        $display("FAIL sb_extra: got beat %h, required no beat", cur_beat);
                    end else begin
                        exp_beat = exp_q.pop_front();
                        if (exp_beat !== cur_beat) begin
                            tests_failed++;
                            $display("FAIL sb_beat: got %h, required %h", cur_beat, exp_beat);
                        end
                    end
                end
                if (out_tlast) begin
                    first_cyc_q.push_back(cur_first);
                    last_cyc_q.push_back(cyc);
                    beats_q.push_back(cur_beats);
                    first_data_q.push_back(cur_first_data);
                    last_keep_q.push_back(out_tkeep);
                    cur_beats = 0;
                end
            end
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [DW-1:0] dest;
        int            nbytes;
        int            exp_beats;
        logic [7:0]    exp_last_keep;
        logic [63:0]   exp_first;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #500000;
        tests_failed++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        int n;
        logic [DW-1:0] dest;

        for (int i = 0; i < 16; i++)
            cfg_tbl[i] = {1'b1, 48'h02AA_0000_0000 | 48'(i), 48'h02BB_0000_0000 | 48'(i), 16'h9000 | 16'(i)};
        cfg_tbl[0] = {1'b1, 48'h0A0B_0C0D_0E0F, 48'h1011_1213_1415, 16'h0800};
        cfg_tbl[1] = {1'b1, 48'h0200_0000_0001, 48'h0200_0000_0002, 16'h88B5};
        cfg_tbl[2] = {1'b0, 48'hDEAD_BEEF_0001, 48'hDEAD_BEEF_0002, 16'h1234};
        cfg_tbl[3] = {1'b1, 48'hF0E1_D2C3_B4A5, 48'h6655_4433_2211, 16'h86DD};

        //            dest    bytes beats lastkeep first-beat
        vecs[0] = '{5'd1,  60, 10, 8'h03, HDR1_BEAT0};
        vecs[1] = '{5'd1,   1,  2, 8'h7F, HDR1_BEAT0};
        vecs[2] = '{5'd1,  16,  4, 8'h3F, HDR1_BEAT0};
        vecs[3] = '{5'd2,  20,  3, 8'h0F, 64'h0807_0605_0403_0201};
        vecs[4] = '{5'd1,   2,  2, 8'hFF, HDR1_BEAT0};
        vecs[5] = '{5'd1,   3,  3, 8'h01, HDR1_BEAT0};
        vecs[6] = '{5'd1,   8,  3, 8'h3F, HDR1_BEAT0};
        vecs[7] = '{5'd17,  9,  3, 8'h7F, HDR1_BEAT0};

        areset     = 1'b1;
        in_tvalid  = 1'b0;
        in_tdata   = '0;
        in_tkeep   = '0;
        in_tlast   = 1'b0;
        in_tdest   = 5'd2;
        out_tready = 1'b1;

        // Reset values (ID 2 is a bypass ID, so tready would be high if not held in reset).
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_tvalid", out_tvalid, 0);
        check("rst_tdata", out_tdata, 0);
        check("rst_tkeep", out_tkeep, 0);
        check("rst_tlast", out_tlast, 0);
        check("rst_tdest", out_tdest, 0);
        check("rst_in_tready", in_tready, 0);
        areset = 1'b0;
        @(posedge aclk);
        #1;

        // Directed table: one packet at a time, full-rate output.
        for (int v = 0; v < 8; v++) begin
            clear_stats();
            fill_pay(vecs[v].nbytes, 1, 1);
            push_expected(vecs[v].dest, vecs[v].nbytes);
            send_pkt(vecs[v].dest, vecs[v].nbytes, 1'b0);
            in_tvalid = 1'b0;
            wait_drain();
            check("vec_pkt_count", beats_q.size(), 1);
            if (beats_q.size() == 1 && start_cyc_q.size() == 1) begin
                check("vec_beats", beats_q[0], vecs[v].exp_beats);
                check("vec_last_keep", last_keep_q[0], vecs[v].exp_last_keep);
                check("vec_first_data", first_data_q[0], vecs[v].exp_first);
                check("vec_latency", first_cyc_q[0] - start_cyc_q[0], 1);
            end
        end

        // Bypass packet followed at once by an encapsulated one: no output gap.
        clear_stats();
        fill_pay(16, 8'h40, 3);
        push_expected(5'd2, 16);
        send_pkt(5'd2, 16, 1'b0);
        fill_pay(24, 8'h90, 5);
        push_expected(5'd1, 24);
        send_pkt(5'd1, 24, 1'b0);
        in_tvalid = 1'b0;
        wait_drain();
        check("b2b_pkt_count", beats_q.size(), 2);
        if (beats_q.size() == 2 && start_cyc_q.size() == 2) begin
            check("b2b_bypass_latency", first_cyc_q[0] - start_cyc_q[0], 1);
            check("b2b_encap_latency", first_cyc_q[1] - start_cyc_q[1], 1);
            check("b2b_no_gap", first_cyc_q[1] - last_cyc_q[0], 1);
            check("b2b_span", last_cyc_q[1] - first_cyc_q[0], 6);
            check("b2b_encap_beats", beats_q[1], 5);
        end

        // Reset asserted while a 5-beat packet is in SHIFT.
        sb_off = 1'b1;
        fill_pay(40, 8'h11, 1);
        begin
            int acc;
            int b;
            bit hs;
            acc = 0;
            b = 0;
            drive_beat(0, 40, 5'd1);
            for (int c = 0; c < 20 && acc < 2; c++) begin
                @(negedge aclk);
                hs = in_tready;
                @(posedge aclk);
                #1;
                if (hs) begin
                    acc++;
                    b++;
                    drive_beat(b, 40, 5'd1);
                end
            end
        end
        @(negedge aclk);
        check("mid_pre_tvalid", out_tvalid, 1);
        areset = 1'b1;
        #1;
        check("mid_rst_tvalid", out_tvalid, 0);
        check("mid_rst_tkeep", out_tkeep, 0);
        check("mid_rst_tdata", out_tdata, 0);
        check("mid_rst_in_tready", in_tready, 0);
        @(posedge aclk);
        #1;
        check("mid_rst_tvalid_edge", out_tvalid, 0);
        in_tvalid = 1'b0;
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        @(posedge aclk);
        #1;
        exp_q.delete();
        clear_stats();
        sb_off = 1'b0;

        fill_pay(20, 8'h70, 7);
        push_expected(5'd1, 20);
        send_pkt(5'd1, 20, 1'b0);
        in_tvalid = 1'b0;
        wait_drain();
        check("post_rst_pkt_count", beats_q.size(), 1);
        if (beats_q.size() == 1 && start_cyc_q.size() == 1) begin
            check("post_rst_beats", beats_q[0], 5);
            check("post_rst_last_keep", last_keep_q[0], 8'h03);
            check("post_rst_first_data", first_data_q[0], HDR1_BEAT0);
            check("post_rst_latency", first_cyc_q[0] - start_cyc_q[0], 1);
        end

        // Random phase: alternating IDs 0/3 (occasionally bypass ID 2),
        // random tdest MSB, random lengths, input gaps and 50% backpressure.
        clear_stats();
        rand_ready = 1'b1;
        for (int p = 0; p < 40; p++) begin
            dest = {1'($urandom_range(0, 1)), ((p % 5 == 4) ? 4'd2 : ((p % 2 == 1) ? 4'd3 : 4'd0))};
            n = $urandom_range(1, 48);
            fill_pay(n, $urandom, $urandom_range(1, 255));
            push_expected(dest, n);
            send_pkt(dest, n, 1'b1);
        end
        in_tvalid = 1'b0;
        wait_drain();
        rand_ready = 1'b0;
        check("rand_pkt_count", beats_q.size(), 40);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
